// File: rtl/lane_mux4to1.sv
// Serializes a 4-lane byte group into one byte per cycle, skipping disabled lanes.
// Latency: first byte is registered and appears 1 cycle after the group is accepted.
// Backpressure: out_ready=0 freezes the output; in_ready opens only on the final byte's transfer.
module lane_mux4to1 (
  input  logic       clkf,
  input  logic       reset,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic       in_valid,
  input  logic [3:0] lane_en,
  output logic       in_ready,
  input  logic       out_ready,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic [1:0] lane_out,
  output logic       last_out
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  // Holding buffer: the group's bytes and its lane mask, captured at acceptance.
  logic [7:0] r_buf [4];
  logic [3:0] r_mask;

  // Registered output byte and its sideband.
  logic [7:0] r_data;
  logic       r_valid;
  logic [1:0] r_lane;
  logic       r_last;

  // Handshake and datapath control.
  logic       w_in_ready;
  logic       w_accept;
  logic       w_load;
  logic       w_step;
  logic       w_drain;

  // Lane selection helpers.
  logic [7:0] w_in [4];
  logic [1:0] w_first;
  logic       w_first_last;
  logic [3:0] w_rem;
  logic [1:0] w_next;
  logic       w_next_last;

  // Index of the lowest set bit; 0 for an empty mask (callers never use that case).
  function automatic logic [1:0] f_lowest(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) idx = 2'(k);
    end
    return idx;
  endfunction

  // Index of the highest set bit; 0 for an empty mask.
  function automatic logic [1:0] f_highest(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) idx = 2'(k);
    end
    return idx;
  endfunction

  assign w_in[0] = in0;
  assign w_in[1] = in1;
  assign w_in[2] = in2;
  assign w_in[3] = in3;

  // First byte of a new group comes straight from the input lanes, so it
  // can be registered on the acceptance edge with no extra cycle.
  assign w_first      = f_lowest(lane_en);
  assign w_first_last = (w_first == f_highest(lane_en));

  // Next byte of the held group: lowest enabled lane strictly above the
  // current one. Shifting a 4-bit constant drops lanes at or below r_lane.
  assign w_rem        = r_mask & (4'b1110 << r_lane);
  assign w_next       = f_lowest(w_rem);
  assign w_next_last  = (w_next == f_highest(r_mask));

  // State register.
  always_ff @(posedge clkf or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: enter SEND on a non-empty group, leave only after the last byte
  // transfers without a replacement group arriving on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_load) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (r_valid && out_ready && r_last) begin
          w_state_nxt = w_load ? ST_SEND : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs of the FSM: ready towards upstream and datapath controls.
  always_comb begin
    w_in_ready = 1'b0;
    w_accept   = 1'b0;
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_drain    = 1'b0;
    case (r_state)
      ST_IDLE: w_in_ready = reset;
      ST_SEND: w_in_ready = reset & r_valid & r_last & out_ready;
      default: w_in_ready = 1'b0;
    endcase
    w_accept = in_valid & w_in_ready;
    // An empty-mask group is accepted but never loads the output.
    w_load   = w_accept & (lane_en != 4'd0);
    w_step   = r_valid & out_ready & ~r_last;
    w_drain  = r_valid & out_ready & r_last & ~w_load;
  end

  // Capture the whole group on acceptance; later bytes are read from here.
  always_ff @(posedge clkf or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        r_buf[k] <= 8'h00;
      end
      r_mask <= 4'd0;
    end else if (w_accept) begin
      for (int k = 0; k < 4; k++) begin
        r_buf[k] <= w_in[k];
      end
      r_mask <= lane_en;
    end
  end

  // Output register: load first byte, step to next lane, or drop valid after the last byte.
  always_ff @(posedge clkf or negedge reset) begin
    if (!reset) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_lane  <= 2'd0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_in[w_first];
      r_valid <= 1'b1;
      r_lane  <= w_first;
      r_last  <= w_first_last;
    end else if (w_step) begin
      r_data  <= r_buf[w_next];
      r_lane  <= w_next;
      r_last  <= w_next_last;
    end else if (w_drain) begin
      // data and lane keep their last values while idle
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign lane_out  = r_lane;
  assign last_out  = r_last;

endmodule

// File: tb/tb_lane_mux4to1.sv
// Bench for lane_mux4to1: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lane_mux4to1;

  logic       clkf      = 1'b0;
  logic       reset     = 1'b0;
  logic [7:0] in0       = 8'h00;
  logic [7:0] in1       = 8'h00;
  logic [7:0] in2       = 8'h00;
  logic [7:0] in3       = 8'h00;
  logic       in_valid  = 1'b0;
  logic [3:0] lane_en   = 4'd0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_out;
  logic       last_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clkf = ~clkf;

  lane_mux4to1 dut (
    .clkf      (clkf),
    .reset     (reset),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in_valid  (in_valid),
    .lane_en   (lane_en),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .data_out  (data_out),
    .valid_out (valid_out),
    .lane_out  (lane_out),
    .last_out  (last_out)
  );

  // Reference model: a queue of the bytes still to be presented. Head of the
  // queue is what the output shows; one entry left means it is the last byte.
  logic [7:0] q_dat [$];
  logic [1:0] q_lane [$];
  logic [7:0] m_dat  = 8'h00;
  logic [1:0] m_lane = 2'd0;

  always @(posedge clkf or negedge reset) begin
    logic       rdy;
    logic [7:0] lanes [4];
    if (!reset) begin
      q_dat.delete();
      q_lane.delete();
      m_dat  = 8'h00;
      m_lane = 2'd0;
    end else begin
      lanes[0] = in0; lanes[1] = in1; lanes[2] = in2; lanes[3] = in3;
      rdy = (q_dat.size() == 0) || (q_dat.size() == 1 && out_ready);
      if (q_dat.size() != 0 && out_ready) begin
        void'(q_dat.pop_front());
        void'(q_lane.pop_front());
      end
      if (in_valid && rdy) begin
        for (int k = 0; k < 4; k++) begin
          if (lane_en[k]) begin
            q_dat.push_back(lanes[k]);
            q_lane.push_back(2'(k));
          end
        end
      end
      if (q_dat.size() != 0) begin
        m_dat  = q_dat[0];
        m_lane = q_lane[0];
      end
    end
  end

  // Every cycle, compare all outputs against the model away from the clock edge.
  always @(negedge clkf) begin
    logic        m_vld, m_last, m_rdy;
    logic [12:0] exp_v, act_v;
    m_vld  = (q_dat.size() != 0);
    m_last = (q_dat.size() == 1);
    m_rdy  = reset && (!m_vld || (m_last && out_ready));
    exp_v  = {m_vld, m_dat, m_lane, m_last, m_rdy};
    act_v  = {valid_out, data_out, lane_out, last_out, in_ready};
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("FAIL model_cmp t=%0t got v=%b d=%h l=%0d last=%b rdy=%b want v=%b d=%h l=%0d last=%b rdy=%b",
               $time, valid_out, data_out, lane_out, last_out, in_ready,
               m_vld, m_dat, m_lane, m_last, m_rdy);
    end
  end

  task automatic cyc();
    @(posedge clkf);
    #1;
  endtask

  task automatic load(input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3,
                      input logic [3:0] m);
    in0 = d0; in1 = d1; in2 = d2; in3 = d3;
    lane_en  = m;
    in_valid = 1'b1;
  endtask

  task automatic expect_o(input string nm, input logic v, input logic [7:0] d,
                          input logic [1:0] l, input logic la);
    n_checks++;
    if ({valid_out, data_out, lane_out, last_out} !== {v, d, l, la}) begin
      n_errors++;
      $display("FAIL %s: got v=%b d=%h l=%0d last=%b want v=%b d=%h l=%0d last=%b",
               nm, valid_out, data_out, lane_out, last_out, v, d, l, la);
    end
  endtask

  task automatic expect_rdy(input string nm, input logic r);
    #1;
    n_checks++;
    if (in_ready !== r) begin
      n_errors++;
      $display("FAIL %s: got in_ready=%b want %b", nm, in_ready, r);
    end
  endtask

  initial begin
    // reset state
    #1;
    expect_o("reset_state", 1'b0, 8'h00, 2'd0, 1'b0);
    expect_rdy("reset_rdy", 1'b0);
    cyc();
    reset = 1'b1;
    out_ready = 1'b1;
    expect_rdy("idle_rdy", 1'b1);

    // full group, streaming
    load(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111);
    cyc(); in_valid = 1'b0;
    expect_o("full_b0", 1'b1, 8'h11, 2'd0, 1'b0);
    cyc(); expect_o("full_b1", 1'b1, 8'h22, 2'd1, 1'b0);
    cyc(); expect_o("full_b2", 1'b1, 8'h33, 2'd2, 1'b0);
    cyc(); expect_o("full_b3", 1'b1, 8'h44, 2'd3, 1'b1);
    cyc(); expect_o("full_idle", 1'b0, 8'h44, 2'd3, 1'b0);

    // sparse mask
    load(8'h00, 8'hA5, 8'h00, 8'h5A, 4'b1010);
    cyc(); in_valid = 1'b0;
    expect_o("sparse_b0", 1'b1, 8'hA5, 2'd1, 1'b0);
    cyc(); expect_o("sparse_b1", 1'b1, 8'h5A, 2'd3, 1'b1);
    cyc(); expect_o("sparse_idle", 1'b0, 8'h5A, 2'd3, 1'b0);

    // backpressure on the second byte, with upstream noise while not ready
    load(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111);
    cyc(); in_valid = 1'b0;
    expect_o("bp_b0", 1'b1, 8'h11, 2'd0, 1'b0);
    cyc(); expect_o("bp_b1", 1'b1, 8'h22, 2'd1, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'b1111);
      expect_rdy("bp_rdy", 1'b0);
      cyc(); expect_o("bp_hold", 1'b1, 8'h22, 2'd1, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc(); expect_o("bp_b2", 1'b1, 8'h33, 2'd2, 1'b0);
    cyc(); expect_o("bp_b3", 1'b1, 8'h44, 2'd3, 1'b1);
    cyc(); expect_o("bp_idle", 1'b0, 8'h44, 2'd3, 1'b0);

    // back-to-back groups with in_valid held high
    load(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111);
    cyc(); expect_o("b2b_b0", 1'b1, 8'h11, 2'd0, 1'b0);
    load(8'h77, 8'h00, 8'h00, 8'h00, 4'b0001);
    expect_rdy("b2b_busy", 1'b0);
    cyc(); expect_o("b2b_b1", 1'b1, 8'h22, 2'd1, 1'b0);
    cyc(); expect_o("b2b_b2", 1'b1, 8'h33, 2'd2, 1'b0);
    cyc(); expect_o("b2b_b3", 1'b1, 8'h44, 2'd3, 1'b1);
    expect_rdy("b2b_edge_rdy", 1'b1);
    cyc(); in_valid = 1'b0;
    expect_o("b2b_77", 1'b1, 8'h77, 2'd0, 1'b1);
    cyc(); expect_o("b2b_idle", 1'b0, 8'h77, 2'd0, 1'b0);

    // empty mask
    load(8'hEE, 8'hEE, 8'hEE, 8'hEE, 4'b0000);
    expect_rdy("empty_rdy0", 1'b1);
    cyc(); in_valid = 1'b0;
    expect_o("empty_out", 1'b0, 8'h77, 2'd0, 1'b0);
    expect_rdy("empty_rdy1", 1'b1);
    cyc(); expect_o("empty_still", 1'b0, 8'h77, 2'd0, 1'b0);

    // reset mid-group
    load(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111);
    cyc(); in_valid = 1'b0;
    expect_o("rst_b0", 1'b1, 8'h11, 2'd0, 1'b0);
    cyc(); expect_o("rst_b1", 1'b1, 8'h22, 2'd1, 1'b0);
    #1 reset = 1'b0;
    #1 expect_o("rst_async", 1'b0, 8'h00, 2'd0, 1'b0);
    expect_rdy("rst_rdy", 1'b0);
    cyc(); expect_o("rst_hold", 1'b0, 8'h00, 2'd0, 1'b0);
    reset = 1'b1;
    load(8'h01, 8'h02, 8'h03, 8'h04, 4'b1111);
    cyc(); in_valid = 1'b0;
    expect_o("post_b0", 1'b1, 8'h01, 2'd0, 1'b0);
    cyc(); expect_o("post_b1", 1'b1, 8'h02, 2'd1, 1'b0);
    cyc(); expect_o("post_b2", 1'b1, 8'h03, 2'd2, 1'b0);
    cyc(); expect_o("post_b3", 1'b1, 8'h04, 2'd3, 1'b1);
    cyc(); expect_o("post_idle", 1'b0, 8'h04, 2'd3, 1'b0);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      cyc();
      in0 = 8'($urandom);
      in1 = 8'($urandom);
      in2 = 8'($urandom);
      in3 = 8'($urandom);
      lane_en = 4'($urandom);
      if ($urandom_range(0, 5) == 0) lane_en = 4'(1 << $urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 199) != 0);
    end
    cyc();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lane_mux4to1.md
LANE_MUX4TO1 -- requirements
Module: lane_mux4to1

Interface
REQ-001 SHALL have port: clkf  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-003 SHALL have ports: in0, in1, in2, in3  input  8 each  byte lanes 0..3 from the upstream 4-lane flop stage.
REQ-004 SHALL have port: in_valid  input  1  the four lanes hold a group to transfer.
REQ-005 SHALL have port: lane_en  input  4  per-lane enable; bit k=1 means lane k carries a byte; sampled with the group.
REQ-006 SHALL have port: in_ready  output  1  combinational; the block accepts a group this cycle.
REQ-007 SHALL have port: out_ready  input  1  downstream accepts the current output byte.
REQ-008 SHALL have port: data_out  output  8  registered serialized byte.
REQ-009 SHALL have port: valid_out  output  1  registered; data_out, lane_out and last_out are valid.
REQ-010 SHALL have port: lane_out  output  2  registered index of the source lane for data_out.
REQ-011 SHALL have port: last_out  output  1  registered; data_out is the final enabled byte of its group.

Function
REQ-012 SHALL have two states: IDLE (no group held) and SEND (group held, bytes being presented).
REQ-013 Acceptance SHALL occur on a rising edge where in_valid=1 and in_ready=1; in0..in3 and lane_en are then captured into a holding buffer.
REQ-014 in_ready SHALL be 1 in IDLE, or in SEND when valid_out=1, last_out=1 and out_ready=1; otherwise 0.
REQ-015 After acceptance with lane_en!=0, the next cycle SHALL present valid_out=1, data_out = the byte of the lowest-index enabled lane, and lane_out = that index; the latency is 1 cycle.
REQ-016 A byte SHALL be transferred on an edge where valid_out=1 and out_ready=1; on that edge the output SHALL advance to the next higher-index enabled lane in the held mask.
REQ-017 While valid_out=1 and out_ready=0, data_out, lane_out, last_out and valid_out SHALL remain unchanged.
REQ-018 last_out SHALL be 1 exactly when lane_out is the highest-index enabled lane of the held mask.
REQ-019 On the transfer of the last byte: if a new group is accepted on the same edge, its first byte SHALL appear the next cycle with no bubble; otherwise the state SHALL return to IDLE and valid_out SHALL go to 0.
REQ-020 A group accepted with lane_en=0 SHALL be consumed in one cycle, produce no output, and leave the state in IDLE.
REQ-021 Disabled lanes SHALL be skipped with no idle cycles; a single-lane mask SHALL produce one byte with last_out=1.
REQ-022 Upstream input changes while in_ready=0 SHALL have no effect on the outputs.
REQ-023 When valid_out=0, data_out and lane_out SHALL hold their previous values, and last_out SHALL be 0.

Reset
REQ-024 When reset=0, the following SHALL take effect asynchronously: state=IDLE, data_out=8'h00, valid_out=0, lane_out=2'd0, last_out=0, and the holding buffer and mask cleared.
REQ-025 Reset asserted during SEND SHALL discard the held group; after release, the first accepted group SHALL be output normally.
REQ-026 While reset=0, in_ready SHALL be 0.

Verification
REQ-027 Full group: in0..3=11,22,33,44, lane_en=4'b1111, out_ready=1 -> data_out 11,22,33,44 on consecutive cycles; lane_out 0..3; last_out only with 44.
REQ-028 Sparse mask: lane_en=4'b1010, in1=A5, in3=5A -> two bytes, A5 (lane 1) then 5A (lane 3, last_out=1); then valid_out=0.
REQ-029 Backpressure: with out_ready=0 for 3 cycles on the second byte -> 22 held stable for 3 cycles; the remaining sequence is unchanged.
REQ-030 Back-to-back: in_valid held at 1 with two groups (mask 1111, then 0001 with in0=77) -> 77 follows the first group's last byte in the next cycle; in_ready=1 on that edge.
REQ-031 Empty mask: lane_en=0 with in_valid=1 -> accepted, valid_out stays 0, and in_ready=1 on the next cycle.
REQ-032 Reset mid-group: reset=0 asserted asynchronously after the second byte -> valid_out=0 and data_out=00 immediately; after release, a new group of 01,02,03,04 is output correctly.
